muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_step.sv | 36 +++
 rtl/muldiv_unit.sv | 139 +++++++++++++
 tb/tb_muldiv_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// default width, funct3 encodings, FSM states and operand signedness rules.
package muldiv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add for multiply,
// restoring shift-subtract for divide. Purely combinational.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            div_mode,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] sreg,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] acc_next,
  output logic [XLEN-1:0] sreg_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic          fits;

  always_comb begin
    sum       = {1'b0, acc} + (sreg[0] ? {1'b0, operand} : '0);
    shifted   = {acc, sreg[XLEN-1]};
    fits      = shifted >= {1'b0, operand};
    acc_next  = '0;
    sreg_next = '0;
    if (div_mode) begin
      // Partial remainder stays below the divisor, so XLEN bits hold the difference.
      acc_next  = fits ? (shifted[XLEN-1:0] - operand) : shifted[XLEN-1:0];
      sreg_next = {sreg[XLEN-2:0], fits};
    end else begin
      acc_next  = sum[XLEN:1];
      sreg_next = {sum[0], sreg[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Fixed-latency RV32M multiply/divide unit: 32 CALC cycles on magnitudes,
// one FIX cycle for sign correction and word selection, one DONE cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  funct3_e           f3_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [XLEN-1:0]   acc_q, sreg_q;
  logic [XLEN-1:0]   result_q;

  logic              accept;
  logic              in_neg_a, in_neg_b;
  logic [XLEN-1:0]   in_mag_a, in_mag_b;
  logic              neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN-1:0]   step_operand;
  logic [XLEN-1:0]   acc_next, sreg_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_result;

  // Magnitudes of the incoming operands, loaded on the accepting edge.
  always_comb begin
    in_neg_a = a_is_signed(funct3) & operand_a[XLEN-1];
    in_neg_b = b_is_signed(funct3) & operand_b[XLEN-1];
    in_mag_a = in_neg_a ? -operand_a : operand_a;
    in_mag_b = in_neg_b ? -operand_b : operand_b;
  end

  always_comb begin
    neg_a        = a_is_signed(f3_q) & a_q[XLEN-1];
    neg_b        = b_is_signed(f3_q) & b_q[XLEN-1];
    mag_a        = neg_a ? -a_q : a_q;
    mag_b        = neg_b ? -b_q : b_q;
    step_operand = is_div_op(f3_q) ? mag_b : mag_a;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .div_mode  (is_div_op(f3_q)),
    .acc       (acc_q),
    .sreg      (sreg_q),
    .operand   (step_operand),
    .acc_next  (acc_next),
    .sreg_next (sreg_next)
  );

  // Divide by zero yields all-ones quotient; the remainder path already returns the dividend.
  always_comb begin
    prod       = {acc_q, sreg_q};
    if (neg_a ^ neg_b) prod = -prod;
    quo        = sreg_q;
    if (b_q == '0)         quo = '1;
    else if (neg_a ^ neg_b) quo = -sreg_q;
    rem        = neg_a ? -acc_q : acc_q;
    fix_result = '0;
    case (f3_q)
      F3_MUL:                        fix_result = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  fix_result = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               fix_result = quo;
      F3_REM, F3_REMU:               fix_result = rem;
      default:                       fix_result = '0;
    endcase
  end

  always_comb begin
    accept  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_CALC;
      S_CALC: begin
        busy = 1'b1;
        if (cnt_q == CNT_W'(XLEN - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        busy    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = start ? S_CALC : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      f3_q     <= F3_MUL;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      sreg_q   <= '0;
      result_q <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      f3_q   <= funct3_e'(funct3);
      a_q    <= operand_a;
      b_q    <= operand_b;
      acc_q  <= '0;
      sreg_q <= is_div_op(funct3) ? in_mag_a : in_mag_b;
    end else if (state_q == S_CALC) begin
      cnt_q  <= cnt_q + 1'b1;
      acc_q  <= acc_next;
      sreg_q <= sreg_next;
    end else if (state_q == S_FIX) begin
      result_q <= fix_result;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// operations compared against a plain-arithmetic RV32M reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        busy, done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .funct3    (funct3),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] sx, zx, sy, zy, p;
    int          sxi, syi;
    logic [31:0] r;
    sx  = {{32{x[31]}}, x};
    zx  = {32'b0, x};
    sy  = {{32{y[31]}}, y};
    zy  = {32'b0, y};
    sxi = x;
    syi = y;
    p   = '0;
    r   = '0;
    case (f3)
      3'b000: begin p = zx * zy; r = p[31:0];  end
      3'b001: begin p = sx * sy; r = p[63:32]; end
      3'b010: begin p = sx * zy; r = p[63:32]; end
      3'b011: begin p = zx * zy; r = p[63:32]; end
      3'b100: begin
        if (y == 0) r = 32'hFFFFFFFF;
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 32'h80000000;
        else r = sxi / syi;
      end
      3'b101: r = (y == 0) ? 32'hFFFFFFFF : x / y;
      3'b110: begin
        if (y == 0) r = x;
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 0;
        else r = sxi % syi;
      end
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  // Called at a negedge; returns just after the accepting edge with inputs scrambled.
  task automatic launch(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    start     = 1'b1;
    funct3    = f3;
    operand_a = x;
    operand_b = y;
    @(posedge clk);
    #1;
    start     = 1'b0;
    funct3    = 3'($urandom);
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  task automatic collect(input int mid, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) check_eq("busy_rise", 32'(busy), 32'd1);
      if (busy) bcnt++;
      if (mid != 0 && n == mid) begin
        start     = 1'b1;
        funct3    = 3'($urandom);
        operand_a = $urandom;
        operand_b = $urandom;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic exec(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y,
                      input int mid, input bit chain, input string tag);
    int          lat, bcnt;
    logic [31:0] exp;
    exp = ref_result(f3, x, y);
    launch(f3, x, y);
    collect(mid, lat, bcnt);
    check_eq({tag, "_res"}, result, exp);
    check_eq({tag, "_lat"}, 32'(lat), 32'd34);
    check_eq({tag, "_busy"}, 32'(bcnt), 32'd33);
    if (!chain) begin
      @(negedge clk);
      check_eq({tag, "_done_once"}, 32'(done), 32'd0);
      check_eq({tag, "_hold"}, result, exp);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dn;
    bit chain;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    exec(F3_MUL,    32'd7,          32'hFFFFFFFD, 0, 1'b0, "mul");
    exec(F3_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 0, 1'b0, "mulhu");
    check_eq("mulhu_const", result, 32'hFFFFFFFE);
    exec(F3_MULH,   32'h80000000,   32'h80000000, 0, 1'b0, "mulh");
    check_eq("mulh_const", result, 32'h40000000);
    exec(F3_MULHSU, 32'hFFFFFFFF,   32'd2,        0, 1'b0, "mulhsu");
    check_eq("mulhsu_const", result, 32'hFFFFFFFF);
    exec(F3_DIV,    32'hFFFFFFF9,   32'd2,        0, 1'b0, "div");
    check_eq("div_const", result, 32'hFFFFFFFD);
    exec(F3_REM,    32'hFFFFFFF9,   32'd2,        0, 1'b0, "rem");
    check_eq("rem_const", result, 32'hFFFFFFFF);
    exec(F3_DIVU,   32'd100,        32'd7,        0, 1'b0, "divu");
    check_eq("divu_const", result, 32'd14);
    exec(F3_REMU,   32'd100,        32'd7,        0, 1'b0, "remu");
    check_eq("remu_const", result, 32'd2);
    exec(F3_DIVU,   32'd5,          32'd0,        0, 1'b0, "divu_z");
    check_eq("divu_z_const", result, 32'hFFFFFFFF);
    exec(F3_REM,    32'd5,          32'd0,        0, 1'b0, "rem_z");
    check_eq("rem_z_const", result, 32'd5);
    exec(F3_DIV,    32'h80000000,   32'hFFFFFFFF, 0, 1'b0, "div_ovf");
    check_eq("div_ovf_const", result, 32'h80000000);
    exec(F3_REM,    32'h80000000,   32'hFFFFFFFF, 0, 1'b0, "rem_ovf");
    check_eq("rem_ovf_const", result, 32'd0);

    exec(F3_MULHU,  32'h12345678,   32'h9ABCDEF0, 10, 1'b0, "mid_ignore");
    exec(F3_DIV,    32'hFFFFFF00,   32'd3,        0, 1'b1, "b2b_first");
    exec(F3_REMU,   32'd1000,       32'd33,       0, 1'b0, "b2b_second");

    launch(F3_MUL, 32'h00001234, 32'h00005678);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_busy", 32'(busy), 32'd0);
    check_eq("async_rst_done", 32'(done), 32'd0);
    check_eq("async_rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    check_eq("no_done_after_rst", 32'(dn), 32'd0);
    exec(F3_MUL, 32'd3, 32'd4, 0, 1'b0, "mul_after_rst");
    check_eq("mul_after_rst_const", result, 32'd12);

    chain = 1'b0;
    for (int i = 0; i < 200; i++) begin
      logic [2:0]  f3;
      logic [31:0] x, y;
      int          mid;
      f3    = 3'($urandom_range(0, 7));
      x     = pick_operand();
      y     = pick_operand();
      mid   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 30)) : 0;
      chain = (i != 199) && ($urandom_range(0, 3) == 0);
      exec(f3, x, y, mid, chain, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
